galvani_frame_parser: RTL and testbench

//  Byte-stream command parser between the NI digital-input byte FIFO and the 4-lane SPI stimulator master.

---
 rtl/galvani_frame_parser.sv | 215 +++++++++++++++++++++
 tb/tb_galvani_frame_parser.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/galvani_frame_parser.sv
// Sync-hunting byte parser feeding the 4-lane SPI stimulator master.
// Optional trailing XOR checksum byte is enabled by defining GALVANI_FRAME_CHECKSUM_EN.
module galvani_frame_parser #(
  parameter int unsigned WORD_BYTES = 2,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA,
  parameter int unsigned ERR_W      = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [7:0]               IN_DATA,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  output logic [1:0]               OUT_CMD,
  output logic [3:0]               OUT_MASK,
  output logic [32*WORD_BYTES-1:0] OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic [ERR_W-1:0]         ERR_CNT,
  output logic                     ERR_PULSE
);
  localparam int unsigned WORD_W = 8 * WORD_BYTES;
  localparam int unsigned DATA_W = 4 * WORD_W;
  localparam int unsigned OFF_W  = $clog2(DATA_W);
  localparam int unsigned BIDX_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BIDX_W-1:0] BIDX_LAST = BIDX_W'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    S_HUNT = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
`ifdef GALVANI_FRAME_CHECKSUM_EN
    S_CHK  = 3'd3,
`endif
    S_HOLD = 3'd4
  } state_t;

`ifdef GALVANI_FRAME_CHECKSUM_EN
  function automatic logic [7:0] xor_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction
  logic [7:0] chk_q, chk_d;
`endif

  state_t              state_q, state_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic [1:0]          out_cmd_q, out_cmd_d;
  logic [3:0]          out_mask_q, out_mask_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
  logic                err_pulse_q, err_pulse_d;
  logic [3:0]          cmd_q, cmd_d;
  logic [3:0]          mask_q, mask_d;
  logic [1:0]          lane_q, lane_d;
  logic [BIDX_W-1:0]   bidx_q, bidx_d;
  logic [DATA_W-1:0]   stage_q, stage_d;
  logic                accept_s, done_s, drop_s, pay_last_s;
  logic [OFF_W-1:0]    off_s;

  // Next-state, staging and output computation for the frame FSM.
  always_comb begin
    state_d     = state_q;
    out_cmd_d   = out_cmd_q;
    out_mask_d  = out_mask_q;
    out_data_d  = out_data_q;
    err_cnt_d   = err_cnt_q;
    err_pulse_d = 1'b0;
    cmd_d       = cmd_q;
    mask_d      = mask_q;
    lane_d      = lane_q;
    bidx_d      = bidx_q;
    stage_d     = stage_q;
`ifdef GALVANI_FRAME_CHECKSUM_EN
    chk_d       = chk_q;
`endif
    done_s      = 1'b0;
    drop_s      = 1'b0;
    accept_s    = IN_VALID & in_ready_q;
    pay_last_s  = (lane_q == 2'd3) && (bidx_q == BIDX_LAST);
    off_s       = OFF_W'(32'(lane_q) * WORD_W + (WORD_BYTES - 32'd1 - 32'(bidx_q)) * 32'd8);

    case (state_q)
      S_HUNT: begin
        if (accept_s && (IN_DATA == SYNC_BYTE)) state_d = S_HDR;
        else state_d = S_HUNT;
      end
      S_HDR: begin
        if (accept_s) begin
          cmd_d  = IN_DATA[7:4];
          mask_d = IN_DATA[3:0];
          lane_d = 2'd0;
          bidx_d = {BIDX_W{1'b0}};
`ifdef GALVANI_FRAME_CHECKSUM_EN
          chk_d  = IN_DATA;
`endif
          case (IN_DATA[7:4])
            4'd1:       state_d = S_PAY;
`ifdef GALVANI_FRAME_CHECKSUM_EN
            4'd2, 4'd3: state_d = S_CHK;
`else
            4'd2, 4'd3: done_s = 1'b1;
`endif
            default:    drop_s = 1'b1;
          endcase
        end else begin
          state_d = S_HDR;
        end
      end
      S_PAY: begin
        if (accept_s) begin
          stage_d[off_s +: 8] = IN_DATA;
`ifdef GALVANI_FRAME_CHECKSUM_EN
          chk_d = xor_fold(chk_q, IN_DATA);
`endif
          if (pay_last_s) begin
`ifdef GALVANI_FRAME_CHECKSUM_EN
            state_d = S_CHK;
`else
            if (mask_q == 4'h0) drop_s = 1'b1;
            else done_s = 1'b1;
`endif
          end else if (bidx_q == BIDX_LAST) begin
            bidx_d = {BIDX_W{1'b0}};
            lane_d = lane_q + 2'd1;
          end else begin
            bidx_d = bidx_q + BIDX_W'(1);
          end
        end else begin
          state_d = S_PAY;
        end
      end
`ifdef GALVANI_FRAME_CHECKSUM_EN
      S_CHK: begin
        // A maskless WRITE is consumed in full, then rejected like a bad checksum.
        if (accept_s) begin
          if ((IN_DATA == chk_q) && !((cmd_q == 4'd1) && (mask_q == 4'h0))) done_s = 1'b1;
          else drop_s = 1'b1;
        end else begin
          state_d = S_CHK;
        end
      end
`endif
      S_HOLD: begin
        if (OUT_READY) state_d = S_HUNT;
        else state_d = S_HOLD;
      end
      default: state_d = S_HUNT;
    endcase

    if (done_s) begin
      state_d    = S_HOLD;
      out_cmd_d  = cmd_d[1:0];
      out_mask_d = mask_d;
      if (cmd_d == 4'd1) out_data_d = stage_d;
      else out_data_d = out_data_q;
    end else if (drop_s) begin
      state_d     = S_HUNT;
      err_pulse_d = 1'b1;
      if (err_cnt_q != {ERR_W{1'b1}}) err_cnt_d = err_cnt_q + ERR_W'(1);
      else err_cnt_d = err_cnt_q;
    end else begin
      err_pulse_d = 1'b0;
    end

    in_ready_d  = (state_d != S_HOLD);
    out_valid_d = (state_d == S_HOLD);
  end

  // Register all state and outputs; RST discards any partial or held frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= S_HUNT;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_cmd_q   <= 2'd0;
      out_mask_q  <= 4'h0;
      out_data_q  <= {DATA_W{1'b0}};
      err_cnt_q   <= {ERR_W{1'b0}};
      err_pulse_q <= 1'b0;
      cmd_q       <= 4'h0;
      mask_q      <= 4'h0;
      lane_q      <= 2'd0;
      bidx_q      <= {BIDX_W{1'b0}};
      stage_q     <= {DATA_W{1'b0}};
`ifdef GALVANI_FRAME_CHECKSUM_EN
      chk_q       <= 8'h00;
`endif
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_cmd_q   <= out_cmd_d;
      out_mask_q  <= out_mask_d;
      out_data_q  <= out_data_d;
      err_cnt_q   <= err_cnt_d;
      err_pulse_q <= err_pulse_d;
      cmd_q       <= cmd_d;
      mask_q      <= mask_d;
      lane_q      <= lane_d;
      bidx_q      <= bidx_d;
      stage_q     <= stage_d;
`ifdef GALVANI_FRAME_CHECKSUM_EN
      chk_q       <= chk_d;
`endif
    end
  end

  assign IN_READY  = in_ready_q;
  assign OUT_VALID = out_valid_q;
  assign OUT_CMD   = out_cmd_q;
  assign OUT_MASK  = out_mask_q;
  assign OUT_DATA  = out_data_q;
  assign ERR_CNT   = err_cnt_q;
  assign ERR_PULSE = err_pulse_q;
endmodule

// File: tb/tb_galvani_frame_parser.sv
// Self-checking bench for galvani_frame_parser (WORD_BYTES=2): directed vectors, then
// randomized frame streams checked against a frame-level model; checksum bytes follow the macro.
module tb_galvani_frame_parser;
  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  out_cmd;
  logic [3:0]  out_mask;
  logic [63:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  err_cnt;
  logic        err_pulse;

  typedef struct packed {
    logic [1:0]  cmd;
    logic [3:0]  mask;
    logic [63:0] data;
  } frame_t;

  int          n_checks = 0;
  int          n_pass = 0;
  int          pulse_cnt = 0;
  int          exp_drops = 0;
  logic [63:0] model_last;
  logic [7:0]  dq[$];
  logic [7:0]  byte_q[$];
  frame_t      exp_q[$];

  galvani_frame_parser #(.WORD_BYTES(2), .SYNC_BYTE(8'hAA), .ERR_W(8)) dut (
    .CLK(clk), .RST(rst), .IN_DATA(in_data), .IN_VALID(in_valid), .IN_READY(in_ready),
    .OUT_CMD(out_cmd), .OUT_MASK(out_mask), .OUT_DATA(out_data), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .ERR_CNT(err_cnt), .ERR_PULSE(err_pulse)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (err_pulse) pulse_cnt++;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame();
`ifdef GALVANI_FRAME_CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int k = 1; k < dq.size(); k++) x ^= dq[k];
`endif
    for (int k = 0; k < dq.size(); k++) send_byte(dq[k]);
`ifdef GALVANI_FRAME_CHECKSUM_EN
    send_byte(x);
`endif
    dq.delete();
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Frame-level model: kind 0 write, 1 trigger, 2 slave reset, 3 bad cmd,
  // 4 maskless write, 5 write with corrupted checksum (plain write without macro), 6 junk.
  task automatic gen_frame(input int kind);
    logic [7:0]  fr[$];
    logic [3:0]  cmd, mask;
    logic [63:0] d;
    logic [15:0] w;
    logic [7:0]  b;
    bit          drop = 0;
    mask = 4'($urandom_range(0, 15));
    if (kind == 6) begin
      for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
        b = 8'($urandom);
        if (b == 8'hAA) b = 8'h55;
        byte_q.push_back(b);
      end
      return;
    end
    case (kind)
      1: cmd = 4'd2;
      2: cmd = 4'd3;
      3: begin
        cmd = 4'($urandom_range(4, 15));
        if ($urandom_range(0, 3) == 0) cmd = 4'd0;
        drop = 1;
      end
      4: begin cmd = 4'd1; mask = 4'h0; drop = 1; end
      default: begin cmd = 4'd1; if (mask == 4'h0) mask = 4'h9; end
    endcase
    fr.push_back(8'hAA);
    fr.push_back({cmd, mask});
    d = model_last;
    if (cmd == 4'd1) begin
      d = 64'h0;
      for (int i = 0; i < 4; i++) begin
        w = 16'h0;
        for (int j = 0; j < 2; j++) begin
          b = 8'($urandom);
          fr.push_back(b);
          w = (w << 8) | 16'(b);
        end
        d = d | (64'(w) << (16 * i));
      end
    end
`ifdef GALVANI_FRAME_CHECKSUM_EN
    if (cmd >= 4'd1 && cmd <= 4'd3) begin
      b = 8'h00;
      for (int k = 1; k < fr.size(); k++) b ^= fr[k];
      if (kind == 5) begin
        b ^= 8'($urandom_range(1, 255));
        drop = 1;
      end
      fr.push_back(b);
    end
`endif
    if (drop) exp_drops++;
    else begin
      exp_q.push_back('{cmd: cmd[1:0], mask: mask, data: d});
      if (cmd == 4'd1) model_last = d;
    end
    foreach (fr[k]) byte_q.push_back(fr[k]);
  endtask

  initial begin
    int   base, cyc;
    bit   rdy, bp_ok;
    frame_t f;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0; model_last = 64'h0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_cmd", out_cmd, 0);
    check_eq("rst_out_mask", out_mask, 0);
    check_eq("rst_out_data", out_data, 0);
    check_eq("rst_err_cnt", err_cnt, 0);
    check_eq("rst_err_pulse", err_pulse, 0);
    rst = 1'b0;
    @(negedge clk);
    check_eq("post_rst_in_ready", in_ready, 1);

    dq = '{8'hAA, 8'h1F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_frame();
    check_eq("wr_latency_valid", out_valid, 1);
    check_eq("wr_hold_in_ready", in_ready, 0);
    check_eq("wr_cmd", out_cmd, 1);
    check_eq("wr_mask", out_mask, 4'hF);
    check_eq("wr_data", out_data, 64'h7788_5566_3344_1122);
    repeat (3) @(negedge clk);
    check_eq("wr_data_stable", out_data, 64'h7788_5566_3344_1122);
    consume();
    check_eq("consumed_valid", out_valid, 0);
    check_eq("consumed_in_ready", in_ready, 1);

    // Reset in the middle of a payload
    send_byte(8'hAA); send_byte(8'h1F);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("midrst_valid", out_valid, 0);
    check_eq("midrst_data", out_data, 0);
    check_eq("midrst_cmd", out_cmd, 0);
    check_eq("midrst_err", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);
    dq = '{8'hAA, 8'h1F, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    send_frame();
    check_eq("after_rst_data", out_data, 64'h0708_0506_0304_0102);
    check_eq("after_rst_err", err_cnt, 0);
    consume();

    send_byte(8'h00); send_byte(8'h13);
    dq = '{8'hAA, 8'h25};
    send_frame();
    check_eq("trig_cmd", out_cmd, 2);
    check_eq("trig_mask", out_mask, 4'h5);
    check_eq("trig_keeps_data", out_data, 64'h0708_0506_0304_0102);
    check_eq("trig_err", err_cnt, 0);
    consume();

    send_byte(8'hAA); send_byte(8'h7F);
    check_eq("badcmd_pulse", err_pulse, 1);
    @(negedge clk);
    check_eq("badcmd_pulse_once", err_pulse, 0);
    check_eq("badcmd_err_cnt", err_cnt, 1);
    check_eq("badcmd_no_valid", out_valid, 0);
    dq = '{8'hAA, 8'h30};
    send_frame();
    check_eq("sreset_cmd", out_cmd, 3);
    check_eq("sreset_mask", out_mask, 4'h0);
    consume();

    // Second frame waits at the input while the first is held
    dq = '{8'hAA, 8'h21};
    send_frame();
    in_valid = 1'b1; in_data = 8'hAA; bp_ok = 1;
    repeat (6) begin
      @(negedge clk);
      if (in_ready || !out_valid) bp_ok = 0;
    end
    in_valid = 1'b0;
    check_eq("backpressure", bp_ok, 1);
    check_eq("held_cmd", out_cmd, 2);
    check_eq("held_mask", out_mask, 4'h1);
    consume();
    dq = '{8'hAA, 8'h1F, 8'hF0, 8'h0F, 8'h5A, 8'hA5, 8'hAA, 8'hAA, 8'h3C, 8'hC3};
    send_frame();
    check_eq("second_cmd", out_cmd, 1);
    check_eq("second_data", out_data, 64'h3CC3_AAAA_5AA5_F00F);
    consume();

`ifdef GALVANI_FRAME_CHECKSUM_EN
    dq = '{8'hAA, 8'h1F, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'hE0};
    foreach (dq[k]) send_byte(dq[k]);
    dq.delete();
    check_eq("badchk_valid", out_valid, 0);
    check_eq("badchk_err", err_cnt, 2);
`endif

    // Randomized stream against the frame-level model
    do_reset();
    model_last = 64'h0;
    exp_drops = 0;
    check_eq("rnd_start_err", err_cnt, 0);
    for (int n = 0; n < 80; n++) gen_frame(int'($urandom_range(0, 6)));
    base = pulse_cnt;
    cyc = 0;
    while ((byte_q.size() > 0 || exp_q.size() > 0) && cyc < 20000) begin
      rdy = ($urandom_range(0, 3) != 0);
      out_ready = rdy;
      if (out_valid && rdy) begin
        if (exp_q.size() == 0) check_eq("rnd_extra_frame", out_valid, 0);
        else begin
          f = exp_q.pop_front();
          check_eq("rnd_cmd", out_cmd, f.cmd);
          check_eq("rnd_mask", out_mask, f.mask);
          check_eq("rnd_data", out_data, f.data);
        end
      end
      if (byte_q.size() > 0 && $urandom_range(0, 4) != 0) begin
        in_valid = 1'b1;
        in_data = byte_q[0];
        if (in_ready) void'(byte_q.pop_front());
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check_eq("rnd_drain", 64'(byte_q.size() + exp_q.size()), 0);
    repeat (3) @(negedge clk);
    check_eq("rnd_err_cnt", err_cnt, 8'(exp_drops));
    check_eq("rnd_pulses", 64'(pulse_cnt - base), 64'(exp_drops));
    check_eq("rnd_idle_valid", out_valid, 0);

    // Error counter saturation
    do_reset();
    base = pulse_cnt;
    for (int n = 0; n < 257; n++) begin
      send_byte(8'hAA);
      send_byte(8'h7F);
    end
    repeat (2) @(negedge clk);
    check_eq("sat_err_cnt", err_cnt, 8'hFF);
    check_eq("sat_pulses", 64'(pulse_cnt - base), 257);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
